// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bus: decode inputs, hazard controls and per-stage control outputs.
// Perf counter signals exist only when CTRL_PERF_EN is defined.
interface ctrl_pipeline_if #(
    parameter int MEM_STAGES = 1
);
    logic [5:0]            opD;
    logic [5:0]            functD;
    logic                  equalD;
    logic                  nequalD;
    logic                  flushE;
    logic                  stallE;
    logic                  pcsrcD;
    logic                  branchD;
    logic                  bneD;
    logic                  jumpD;
    logic                  extendD;
    logic                  stall_mduD;
    logic                  alusrcE;
    logic                  regdstE;
    logic                  regwriteE;
    logic                  memtoregE;
    logic [3:0]            alucontrolE;
    logic                  mduopE;
    logic                  memwriteM;
    logic [MEM_STAGES-1:0] regwriteM_vec;
    logic [MEM_STAGES-1:0] memtoregM_vec;
    logic                  regwriteW;
    logic                  memtoregW;
    logic                  mdu_busy;
`ifdef CTRL_PERF_EN
    logic [31:0]           perf_bubbles;
    logic [31:0]           perf_mdu_stall;

    modport master (
        output opD, functD, equalD, nequalD, flushE, stallE,
        input  pcsrcD, branchD, bneD, jumpD, extendD, stall_mduD,
        input  alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, mduopE,
        input  memwriteM, regwriteM_vec, memtoregM_vec, regwriteW, memtoregW, mdu_busy,
        input  perf_bubbles, perf_mdu_stall
    );
    modport slave (
        input  opD, functD, equalD, nequalD, flushE, stallE,
        output pcsrcD, branchD, bneD, jumpD, extendD, stall_mduD,
        output alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, mduopE,
        output memwriteM, regwriteM_vec, memtoregM_vec, regwriteW, memtoregW, mdu_busy,
        output perf_bubbles, perf_mdu_stall
    );
`else
    modport master (
        output opD, functD, equalD, nequalD, flushE, stallE,
        input  pcsrcD, branchD, bneD, jumpD, extendD, stall_mduD,
        input  alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, mduopE,
        input  memwriteM, regwriteM_vec, memtoregM_vec, regwriteW, memtoregW, mdu_busy
    );
    modport slave (
        input  opD, functD, equalD, nequalD, flushE, stallE,
        output pcsrcD, branchD, bneD, jumpD, extendD, stall_mduD,
        output alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, mduopE,
        output memwriteM, regwriteM_vec, memtoregM_vec, regwriteW, memtoregW, mdu_busy
    );
`endif
endinterface

// File: rtl/ctrl_pipeline.sv
// Pipelined MIPS control unit: D decode, E/M1..Mn/W control registers and an MDU busy tracker.
// Optional CTRL_PERF_EN adds saturating bubble and MDU-stall cycle counters.
module ctrl_pipeline #(
    parameter int MEM_STAGES = 1,
    parameter int MDU_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);
    localparam int CNT_W = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_CYCLES - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic [3:0] alucontrol;
        logic       mduop;
    } eCtl_t;

    typedef enum logic {MDU_IDLE = 1'b0, MDU_BUSY = 1'b1} mduState_t;

    logic       regwriteD_s, regdstD_s, alusrcD_s, memwriteD_s, memtoregD_s;
    logic       branchD_s, bneD_s, jumpD_s, extendD_s;
    logic [1:0] aluOp_s;
    logic [3:0] immAlu_s;
    logic [3:0] alucontrolD_s;
    logic       mduopD_s, mfhiloD_s, stallMduD_s;
    eCtl_t      eCtl_r;

    logic [MEM_STAGES-1:0] regwriteM_r, memtoregM_r;
    logic                  memwriteM_r, regwriteW_r, memtoregW_r;
    mduState_t             mduState_r;
    logic [CNT_W-1:0]      mduCnt_r;
    logic                  mduBusy_r;

    // Main decoder: aluOp 00=add, 01=sub, 10=funct field, 11=immediate-specific op
    always_comb begin
        regwriteD_s = 1'b0;
        regdstD_s   = 1'b0;
        alusrcD_s   = 1'b0;
        memwriteD_s = 1'b0;
        memtoregD_s = 1'b0;
        branchD_s   = 1'b0;
        bneD_s      = 1'b0;
        jumpD_s     = 1'b0;
        extendD_s   = 1'b0;
        aluOp_s     = 2'b00;
        immAlu_s    = ALU_ADD;
        case (bus.opD)
            OP_RTYPE: begin regwriteD_s = 1'b1; regdstD_s = 1'b1; aluOp_s = 2'b10; end
            OP_LW:    begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; memtoregD_s = 1'b1; extendD_s = 1'b1; end
            OP_SW:    begin alusrcD_s = 1'b1; memwriteD_s = 1'b1; extendD_s = 1'b1; end
            OP_BEQ:   begin branchD_s = 1'b1; extendD_s = 1'b1; aluOp_s = 2'b01; end
            OP_BNE:   begin bneD_s = 1'b1; extendD_s = 1'b1; aluOp_s = 2'b01; end
            OP_ADDI,
            OP_ADDIU: begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; extendD_s = 1'b1; end
            OP_SLTI:  begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; extendD_s = 1'b1; aluOp_s = 2'b11; immAlu_s = ALU_SLT; end
            OP_SLTIU: begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; extendD_s = 1'b1; aluOp_s = 2'b11; immAlu_s = ALU_SLTU; end
            OP_ANDI:  begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; aluOp_s = 2'b11; immAlu_s = ALU_AND; end
            OP_ORI:   begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; aluOp_s = 2'b11; immAlu_s = ALU_OR; end
            OP_XORI:  begin regwriteD_s = 1'b1; alusrcD_s = 1'b1; aluOp_s = 2'b11; immAlu_s = ALU_XOR; end
            OP_J:     begin jumpD_s = 1'b1; end
            default:  begin regwriteD_s = 1'b0; end
        endcase
    end

    // ALU decoder: R-type functs without an ALU meaning fall back to add
    always_comb begin
        alucontrolD_s = ALU_ADD;
        case (aluOp_s)
            2'b00: alucontrolD_s = ALU_ADD;
            2'b01: alucontrolD_s = ALU_SUB;
            2'b10: begin
                case (bus.functD)
                    6'h20, 6'h21: alucontrolD_s = ALU_ADD;
                    6'h22, 6'h23: alucontrolD_s = ALU_SUB;
                    6'h24:        alucontrolD_s = ALU_AND;
                    6'h25:        alucontrolD_s = ALU_OR;
                    6'h26:        alucontrolD_s = ALU_XOR;
                    6'h27:        alucontrolD_s = ALU_NOR;
                    6'h2A:        alucontrolD_s = ALU_SLT;
                    6'h2B:        alucontrolD_s = ALU_SLTU;
                    default:      alucontrolD_s = ALU_ADD;
                endcase
            end
            2'b11:   alucontrolD_s = immAlu_s;
            default: alucontrolD_s = ALU_ADD;
        endcase
    end

    assign mduopD_s    = (bus.opD == OP_RTYPE) && (bus.functD inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign mfhiloD_s   = (bus.opD == OP_RTYPE) && (bus.functD inside {6'h10, 6'h12});
    // A mult/div still sitting in E counts as busy before the tracker has started
    assign stallMduD_s = (mfhiloD_s | mduopD_s) & (mduBusy_r | eCtl_r.mduop);

    assign bus.pcsrcD     = (branchD_s & bus.equalD) | (bneD_s & bus.nequalD);
    assign bus.branchD    = branchD_s;
    assign bus.bneD       = bneD_s;
    assign bus.jumpD      = jumpD_s;
    assign bus.extendD    = extendD_s;
    assign bus.stall_mduD = stallMduD_s;

    // E stage register: reset/flush clear it, stall holds it
    always_ff @(posedge clk) begin
        if (reset || bus.flushE) begin
            eCtl_r <= '0;
        end else if (bus.stallE) begin
            eCtl_r <= eCtl_r;
        end else begin
            eCtl_r <= '{memtoreg: memtoregD_s, memwrite: memwriteD_s, alusrc: alusrcD_s,
                        regdst: regdstD_s, regwrite: regwriteD_s,
                        alucontrol: alucontrolD_s, mduop: mduopD_s};
        end
    end

    // M1..Mn and W registers; M1 takes a bubble while E is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            regwriteM_r <= '0;
            memtoregM_r <= '0;
            memwriteM_r <= 1'b0;
            regwriteW_r <= 1'b0;
            memtoregW_r <= 1'b0;
        end else begin
            if (bus.stallE) begin
                regwriteM_r[0] <= 1'b0;
                memtoregM_r[0] <= 1'b0;
                memwriteM_r    <= 1'b0;
            end else begin
                regwriteM_r[0] <= eCtl_r.regwrite;
                memtoregM_r[0] <= eCtl_r.memtoreg;
                memwriteM_r    <= eCtl_r.memwrite;
            end
            for (int k = 1; k < MEM_STAGES; k++) begin
                regwriteM_r[k] <= regwriteM_r[k-1];
                memtoregM_r[k] <= memtoregM_r[k-1];
            end
            regwriteW_r <= regwriteM_r[MEM_STAGES-1];
            memtoregW_r <= memtoregM_r[MEM_STAGES-1];
        end
    end

    // MDU busy tracker: starts when a mult/div leaves E, busy for exactly MDU_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            mduState_r <= MDU_IDLE;
            mduCnt_r   <= '0;
            mduBusy_r  <= 1'b0;
        end else begin
            case (mduState_r)
                MDU_IDLE: begin
                    if (eCtl_r.mduop && !bus.stallE && !bus.flushE) begin
                        mduState_r <= MDU_BUSY;
                        mduCnt_r   <= CNT_INIT;
                        mduBusy_r  <= 1'b1;
                    end else begin
                        mduState_r <= MDU_IDLE;
                        mduBusy_r  <= 1'b0;
                    end
                end
                MDU_BUSY: begin
                    if (mduCnt_r == '0) begin
                        mduState_r <= MDU_IDLE;
                        mduBusy_r  <= 1'b0;
                    end else begin
                        mduCnt_r   <= mduCnt_r - CNT_W'(1);
                        mduBusy_r  <= 1'b1;
                    end
                end
                default: begin
                    mduState_r <= MDU_IDLE;
                    mduCnt_r   <= '0;
                    mduBusy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alusrcE       = eCtl_r.alusrc;
    assign bus.regdstE       = eCtl_r.regdst;
    assign bus.regwriteE     = eCtl_r.regwrite;
    assign bus.memtoregE     = eCtl_r.memtoreg;
    assign bus.alucontrolE   = eCtl_r.alucontrol;
    assign bus.mduopE        = eCtl_r.mduop;
    assign bus.memwriteM     = memwriteM_r;
    assign bus.regwriteM_vec = regwriteM_r;
    assign bus.memtoregM_vec = memtoregM_r;
    assign bus.regwriteW     = regwriteW_r;
    assign bus.memtoregW     = memtoregW_r;
    assign bus.mdu_busy      = mduBusy_r;

`ifdef CTRL_PERF_EN
    logic [31:0] perfBubbles_r, perfMduStall_r;

    // Saturating cycle counters for pipeline bubbles and MDU decode stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            perfBubbles_r  <= 32'd0;
            perfMduStall_r <= 32'd0;
        end else begin
            if ((bus.flushE || bus.stallE) && (perfBubbles_r != 32'hFFFF_FFFF)) begin
                perfBubbles_r <= perfBubbles_r + 32'd1;
            end
            if (stallMduD_s && (perfMduStall_r != 32'hFFFF_FFFF)) begin
                perfMduStall_r <= perfMduStall_r + 32'd1;
            end
        end
    end

    assign bus.perf_bubbles   = perfBubbles_r;
    assign bus.perf_mdu_stall = perfMduStall_r;
`endif
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized and directed bench for ctrl_pipeline (MEM_STAGES=2, MDU_CYCLES=4) against a
// cycle-level reference model built from the decode table, a stage queue and a busy countdown.
module tb_ctrl_pipeline;
    localparam int MS = 2;
    localparam int MC = 4;

    typedef struct packed {
        logic branch, bne, jump, extend;
        logic regwrite, regdst, alusrc, memwrite, memtoreg, mduop, mfhilo;
        logic [3:0] aluc;
    } decT;

    typedef struct packed {
        logic memtoreg, memwrite, regwrite;
    } mCtlT;

    logic clk = 1'b0;
    logic reset;
    ctrl_pipeline_if #(.MEM_STAGES(MS)) bus ();

    ctrl_pipeline #(.MEM_STAGES(MS), .MDU_CYCLES(MC)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;

    decT  eCtl;
    mCtlT mq[$];
    logic wMtr, wRw;
    int   busyLeft;
    logic [31:0] perfB, perfM;
    logic hazardFlush = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rAlu(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b0100;
            6'h2A: return 4'b0111;
            6'h2B: return 4'b1000;
            default: return 4'b0010;
        endcase
    endfunction

    // Instruction-class table: each row lists the controls the instruction needs
    function automatic decT decode(input logic [5:0] op, input logic [5:0] fn);
        decT d = '0;
        d.aluc = 4'b0010;
        case (op)
            6'h00: begin d.regwrite = 1'b1; d.regdst = 1'b1; d.aluc = rAlu(fn);
                         d.mduop = (fn >= 6'h18 && fn <= 6'h1B);
                         d.mfhilo = (fn == 6'h10 || fn == 6'h12); end
            6'h23: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.memtoreg = 1'b1; d.extend = 1'b1; end
            6'h2B: begin d.alusrc = 1'b1; d.memwrite = 1'b1; d.extend = 1'b1; end
            6'h04: begin d.branch = 1'b1; d.extend = 1'b1; d.aluc = 4'b0110; end
            6'h05: begin d.bne = 1'b1; d.extend = 1'b1; d.aluc = 4'b0110; end
            6'h08, 6'h09: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.extend = 1'b1; end
            6'h0A: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.extend = 1'b1; d.aluc = 4'b0111; end
            6'h0B: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.extend = 1'b1; d.aluc = 4'b1000; end
            6'h0C: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.aluc = 4'b0000; end
            6'h0D: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.aluc = 4'b0001; end
            6'h0E: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.aluc = 4'b0011; end
            6'h02: d.jump = 1'b1;
            default: d.aluc = 4'b0010;
        endcase
        return d;
    endfunction

    task automatic resetModel();
        eCtl = '0;
        mq = {};
        for (int k = 0; k < MS; k++) mq.push_back('0);
        wMtr = 1'b0;
        wRw = 1'b0;
        busyLeft = 0;
        perfB = 32'd0;
        perfM = 32'd0;
    endtask

    // One clock: drive, compare every output against the model, clock, advance the model
    task automatic runCycle(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic neq,
                            input logic fl, input logic st, input logic rs,
                            output logic stallSeen, output logic busySeen);
        decT d;
        logic stallM, flE;
        logic [MS-1:0] expRw, expMtr;
        mCtlT leaving;
        d = decode(op, fn);
        stallM = (d.mduop | d.mfhilo) & ((busyLeft > 0) | eCtl.mduop);
        flE = fl | (hazardFlush & stallM);
        bus.opD = op; bus.functD = fn; bus.equalD = eq; bus.nequalD = neq;
        bus.flushE = flE; bus.stallE = st; reset = rs;
        #1;
        for (int k = 0; k < MS; k++) begin
            expRw[k] = mq[k].regwrite;
            expMtr[k] = mq[k].memtoreg;
        end
        checkEq("pcsrcD", bus.pcsrcD, (d.branch & eq) | (d.bne & neq));
        checkEq("branchD", bus.branchD, d.branch);
        checkEq("bneD", bus.bneD, d.bne);
        checkEq("jumpD", bus.jumpD, d.jump);
        checkEq("extendD", bus.extendD, d.extend);
        checkEq("stall_mduD", bus.stall_mduD, stallM);
        checkEq("alusrcE", bus.alusrcE, eCtl.alusrc);
        checkEq("regdstE", bus.regdstE, eCtl.regdst);
        checkEq("regwriteE", bus.regwriteE, eCtl.regwrite);
        checkEq("memtoregE", bus.memtoregE, eCtl.memtoreg);
        checkEq("alucontrolE", bus.alucontrolE, eCtl.aluc);
        checkEq("mduopE", bus.mduopE, eCtl.mduop);
        checkEq("memwriteM", bus.memwriteM, mq[0].memwrite);
        checkEq("regwriteM_vec", bus.regwriteM_vec, expRw);
        checkEq("memtoregM_vec", bus.memtoregM_vec, expMtr);
        checkEq("regwriteW", bus.regwriteW, wRw);
        checkEq("memtoregW", bus.memtoregW, wMtr);
        checkEq("mdu_busy", bus.mdu_busy, busyLeft > 0);
`ifdef CTRL_PERF_EN
        checkEq("perf_bubbles", bus.perf_bubbles, perfB);
        checkEq("perf_mdu_stall", bus.perf_mdu_stall, perfM);
`endif
        stallSeen = bus.stall_mduD;
        busySeen = bus.mdu_busy;
        @(posedge clk);
        if (rs) begin
            resetModel();
        end else begin
            if ((flE | st) && perfB != 32'hFFFF_FFFF) perfB = perfB + 32'd1;
            if (stallM && perfM != 32'hFFFF_FFFF) perfM = perfM + 32'd1;
            if (busyLeft > 0) busyLeft--;
            else if (eCtl.mduop && !st && !flE) busyLeft = MC;
            leaving = mq[MS-1];
            wMtr = leaving.memtoreg;
            wRw = leaving.regwrite;
            void'(mq.pop_back());
            mq.push_front(st ? mCtlT'('0) : mCtlT'({eCtl.memtoreg, eCtl.memwrite, eCtl.regwrite}));
            if (flE) eCtl = '0;
            else if (!st) eCtl = d;
        end
        #1;
    endtask

    logic [5:0] opList [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h0E};
    logic [5:0] fnList [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h27};

    initial begin
        logic s, b;
        logic [5:0] op, fn;
        logic eq, neq;
        reset = 1'b1;
        bus.opD = 6'h00; bus.functD = 6'h00; bus.equalD = 1'b0; bus.nequalD = 1'b0;
        bus.flushE = 1'b0; bus.stallE = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_regwriteE", bus.regwriteE, 1'b0);
        checkEq("rst_regwriteW", bus.regwriteW, 1'b0);
        checkEq("rst_mdu_busy", bus.mdu_busy, 1'b0);

        // Three flush bubbles, then mult in E followed by a dependent mflo
        repeat (3) runCycle(6'h00, 6'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s, b);
        runCycle(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        for (int i = 0; i <= 5; i++) begin
            runCycle(6'h00, 6'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
            checkEq($sformatf("mdu_stall_t%0d", i), s, i <= 4);
            checkEq($sformatf("mdu_busy_t%0d", i), b, (i >= 1) && (i <= 4));
        end
`ifdef CTRL_PERF_EN
        checkEq("perf_bubbles_3", bus.perf_bubbles, 32'd3);
        checkEq("perf_mdu_stall_5", bus.perf_mdu_stall, 32'd5);
`endif

        // Reset while the MDU is busy
        runCycle(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        for (int i = 0; i <= 3; i++) begin
            runCycle(6'h00, 6'h12, 1'b0, 1'b0, 1'b0, 1'b0, i == 2, s, b);
            checkEq($sformatf("rstmdu_stall_t%0d", i), s, i <= 2);
            checkEq($sformatf("rstmdu_busy_t%0d", i), b, (i >= 1) && (i <= 2));
        end

        // lw walks E, M1, M2, W
        runCycle(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        checkEq("lw_memtoregE", bus.memtoregE, 1'b1);
        runCycle(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        checkEq("lw_M1", bus.memtoregM_vec, 2'b01);
        runCycle(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        checkEq("lw_M2", bus.memtoregM_vec, 2'b10);
        runCycle(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        checkEq("lw_memtoregW", bus.memtoregW, 1'b1);
        checkEq("lw_regwriteW", bus.regwriteW, 1'b1);

        // Branch resolution
        bus.opD = 6'h04; bus.functD = 6'h00; bus.equalD = 1'b1; bus.nequalD = 1'b0;
        #1 checkEq("beq_taken", bus.pcsrcD, 1'b1);
        bus.equalD = 1'b0; bus.nequalD = 1'b1;
        #1 checkEq("beq_not_taken", bus.pcsrcD, 1'b0);
        bus.opD = 6'h05;
        #1 checkEq("bne_taken", bus.pcsrcD, 1'b1);

        // sw flushed in D never writes memory
        runCycle(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s, b);
        checkEq("sw_flush_alusrcE", bus.alusrcE, 1'b0);
        checkEq("sw_flush_alucE", bus.alucontrolE, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            runCycle(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
            checkEq("sw_flush_memwriteM", bus.memwriteM, 1'b0);
        end

        // add held in E for two stall cycles, reaches M1 exactly once
        runCycle(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        for (int i = 0; i < 2; i++) begin
            runCycle(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, b);
            checkEq("stall_hold_regwriteE", bus.regwriteE, 1'b1);
            checkEq("stall_hold_alucE", bus.alucontrolE, 4'b0010);
            checkEq("stall_bubble_M1", bus.regwriteM_vec[0], 1'b0);
        end
        runCycle(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        checkEq("stall_release_M1", bus.regwriteM_vec[0], 1'b1);
        runCycle(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, b);
        checkEq("stall_once_M1", bus.regwriteM_vec[0], 1'b0);

        // Random traffic with a hazard unit that flushes on MDU stalls
        hazardFlush = 1'b1;
        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : opList[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 9)];
            eq = 1'($urandom_range(0, 1));
            neq = ($urandom_range(0, 3) == 0) ? eq : ~eq;
            runCycle(op, fn, eq, neq, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 99) == 0, s, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
